mem_bus_arbiter: RTL and testbench

- Shares the single memory port (address, write data, write enable, read data) between two requesters.
- Master 0 is the CPU fetch/load/store path; master 1 is a DMA/program loader.
- Serialises accesses and returns read data with a valid pulse to the winning master.
- Sits between the masters and the memory module; all memory-side outputs are registered.

---
 rtl/mem_bus_arbiter.sv | 115 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single memory port; all memory-side outputs registered.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin, otherwise m0 has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned BITS_DATA   = 32,
  parameter int unsigned BITS_ADDR   = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_write,
  input  logic [BITS_ADDR-1:0] m0_addr,
  input  logic [BITS_DATA-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  input  logic                 m1_req,
  input  logic                 m1_write,
  input  logic [BITS_ADDR-1:0] m1_addr,
  input  logic [BITS_DATA-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [BITS_DATA-1:0] rdata,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [BITS_DATA-1:0] mem_rdata,
  output logic                 busy
);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : gLatencyCheck
      $fatal(1, "mem_bus_arbiter: MEM_LATENCY must be in 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic       winner;   // 1 = master 1 owns the current access
  logic       isWrite;  // mem_write drops after ISSUE, so the access kind is kept here
  logic [2:0] cnt;
  logic       pickM1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastM1;
  always_comb pickM1 = m1_req & (~m0_req | ~lastM1);
`else
  always_comb pickM1 = m1_req & ~m0_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      winner    <= 1'b0;
      isWrite   <= 1'b0;
      cnt       <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastM1    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            winner    <= pickM1;
            isWrite   <= pickM1 ? m1_write : m0_write;
            mem_write <= pickM1 ? m1_write : m0_write;
            mem_addr  <= pickM1 ? m1_addr : m0_addr;
            mem_wdata <= pickM1 ? m1_wdata : m0_wdata;
            m0_gnt    <= ~pickM1;
            m1_gnt    <= pickM1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m0_gnt    <= 1'b0;
          m1_gnt    <= 1'b0;
          mem_write <= 1'b0;
          cnt       <= 3'(MEM_LATENCY - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            rdata     <= isWrite ? '0 : mem_rdata;
            m0_rvalid <= ~winner;
            m1_rvalid <= winner;
            state     <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          lastM1    <= winner;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// each with a small behavioural memory whose read data arrives MEM_LATENCY cycles after issue.
module tb_mem_bus_arbiter;

  logic        clk, reset, memInit;
  int          total = 0;
  int          bad = 0;

  // latency-1 instance
  logic        m0_req, m0_write, m0_gnt, m0_rvalid;
  logic        m1_req, m1_write, m1_gnt, m1_rvalid;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wdata, m1_wdata, rdata, mem_wdata, mem_rdata;
  logic        mem_write, busy;

  // latency-3 instance
  logic        l3_m0_req, l3_m0_write, l3_m0_gnt, l3_m0_rvalid;
  logic        l3_m1_req, l3_m1_write, l3_m1_gnt, l3_m1_rvalid;
  logic [15:0] l3_m0_addr, l3_m1_addr, l3_mem_addr;
  logic [31:0] l3_m0_wdata, l3_m1_wdata, l3_rdata, l3_mem_wdata, l3_mem_rdata;
  logic        l3_mem_write, l3_busy;

  mem_bus_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(l3_m0_req), .m0_write(l3_m0_write), .m0_addr(l3_m0_addr), .m0_wdata(l3_m0_wdata),
    .m0_gnt(l3_m0_gnt), .m0_rvalid(l3_m0_rvalid),
    .m1_req(l3_m1_req), .m1_write(l3_m1_write), .m1_addr(l3_m1_addr), .m1_wdata(l3_m1_wdata),
    .m1_gnt(l3_m1_gnt), .m1_rvalid(l3_m1_rvalid),
    .rdata(l3_rdata), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_write(l3_mem_write),
    .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem  [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] rd1, p0, p1, p2;

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= '0;
        mem3[i] <= '0;
      end
      mem[5]  <= 32'h12345678;
      mem3[0] <= 32'h11111111;
      mem3[7] <= 32'hCAFEF00D;
    end else begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      rd1 <= mem[mem_addr[7:0]];
      if (l3_mem_write) mem3[l3_mem_addr[7:0]] <= l3_mem_wdata;
      p0 <= mem3[l3_mem_addr[7:0]];
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign mem_rdata    = rd1;
  assign l3_mem_rdata = p2;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mutual exclusion of pulses and mem_write only alongside a grant, every cycle.
  always @(negedge clk) begin
    if (!reset && !memInit) begin
      chk1("excl", (m0_gnt & m1_gnt) | (m0_rvalid & m1_rvalid) | (mem_write & ~(m0_gnt | m1_gnt)), 1'b0);
      chk1("excl3", (l3_m0_gnt & l3_m1_gnt) | (l3_mem_write & ~(l3_m0_gnt | l3_m1_gnt)), 1'b0);
    end
  end

  // Uncontended access on the latency-1 instance, starting from IDLE.
  task automatic doAccess(input logic m, input logic wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [31:0] expR, input string tag);
    if (m) begin
      m1_req = 1'b1; m1_write = wr; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_write = wr; m0_addr = a; m0_wdata = wd;
    end
    @(negedge clk);
    chk1({tag, ".gnt"}, m ? m1_gnt : m0_gnt, 1'b1);
    chk1({tag, ".otherGnt"}, m ? m0_gnt : m1_gnt, 1'b0);
    chk1({tag, ".memWrite"}, mem_write, wr);
    chk16({tag, ".memAddr"}, mem_addr, a);
    chk32({tag, ".memWdata"}, mem_wdata, wd);
    chk1({tag, ".busyIssue"}, busy, 1'b1);
    m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
    @(negedge clk);
    chk1({tag, ".gntDrop"}, m ? m1_gnt : m0_gnt, 1'b0);
    chk1({tag, ".memWriteWait"}, mem_write, 1'b0);
    chk1({tag, ".rvalidEarly"}, m ? m1_rvalid : m0_rvalid, 1'b0);
    chk16({tag, ".memAddrHold"}, mem_addr, a);
    @(negedge clk);
    chk1({tag, ".rvalid"}, m ? m1_rvalid : m0_rvalid, 1'b1);
    chk1({tag, ".otherRvalid"}, m ? m0_rvalid : m1_rvalid, 1'b0);
    chk32({tag, ".rdata"}, rdata, expR);
    chk1({tag, ".busyDone"}, busy, 1'b1);
    @(negedge clk);
    chk1({tag, ".rvalidDrop"}, m ? m1_rvalid : m0_rvalid, 1'b0);
    chk1({tag, ".busyIdle"}, busy, 1'b0);
  endtask

  task automatic waitGnt(output int who);
    who = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0_gnt) begin who = 0; break; end
      if (m1_gnt) begin who = 1; break; end
    end
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk1(tag, busy, 1'b0);
  endtask

  int who, expWho, n0;

  initial begin
    reset = 1'b1; memInit = 1'b1;
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    l3_m0_req = 0; l3_m0_write = 0; l3_m0_addr = '0; l3_m0_wdata = '0;
    l3_m1_req = 0; l3_m1_write = 0; l3_m1_addr = '0; l3_m1_wdata = '0;
    repeat (3) @(negedge clk);
    memInit = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk1("rst.m0Gnt", m0_gnt, 1'b0);
    chk1("rst.m1Gnt", m1_gnt, 1'b0);
    chk1("rst.rvalid", m0_rvalid | m1_rvalid, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.memWrite", mem_write, 1'b0);
    chk16("rst.memAddr", mem_addr, 16'h0000);
    chk32("rst.rdata", rdata, 32'h0);
    chk1("rst.busy3", l3_busy, 1'b0);

    // 1: m0 load; 2: m1 store then m0 readback
    doAccess(1'b0, 1'b0, 16'h0005, 32'h0, 32'h12345678, "t1");
    doAccess(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, "t2st");
    doAccess(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, "t2ld");

    // 3: both masters request continuously, four accesses each
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 16'h0005;
    m1_req = 1'b1; m1_write = 1'b0; m1_addr = 16'h0010;
    n0 = 0;
    for (int g = 0; g < 8; g++) begin
      waitGnt(who);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expWho = g % 2;
`else
      expWho = (g < 4) ? 0 : 1;
`endif
      chk32($sformatf("t3.order%0d", g), 32'(who), 32'(expWho));
      if (who == 0) begin
        n0++;
        if (n0 == 4) m0_req = 1'b0;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    waitIdle("t3.idle");

    // 4: latency 3 instance, stale read data sits in the pipeline until cycle 3
    l3_m0_req = 1'b1; l3_m0_addr = 16'h0007; l3_m0_write = 1'b0;
    @(negedge clk);
    chk1("t4.gnt", l3_m0_gnt, 1'b1);
    chk1("t4.busyGnt", l3_busy, 1'b1);
    l3_m0_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk1($sformatf("t4.busy%0d", k), l3_busy, 1'b1);
      chk1($sformatf("t4.rvalid%0d", k), l3_m0_rvalid, (k == 4));
    end
    chk32("t4.rdata", l3_rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk1("t4.busyEnd", l3_busy, 1'b0);
    chk1("t4.rvalidEnd", l3_m0_rvalid, 1'b0);

    // 5: m0 completes last, then an m1 load is killed by reset in WAIT
    doAccess(1'b0, 1'b0, 16'h0005, 32'h0, 32'h12345678, "t5pre");
    m1_req = 1'b1; m1_addr = 16'h0010; m1_write = 1'b0;
    @(negedge clk);
    chk1("t5.m1Gnt", m1_gnt, 1'b1);
    m1_req = 1'b0;
    @(negedge clk);
    chk1("t5.busyWait", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk1("t5.rstBusy", busy, 1'b0);
    chk1("t5.rstGnt", m0_gnt | m1_gnt, 1'b0);
    chk1("t5.rstRvalid", m0_rvalid | m1_rvalid, 1'b0);
    chk1("t5.rstMemWrite", mem_write, 1'b0);
    chk16("t5.rstMemAddr", mem_addr, 16'h0000);
    chk32("t5.rstMemWdata", mem_wdata, 32'h0);
    chk32("t5.rstRdata", rdata, 32'h0);
    #3;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("t5.noRvalid%0d", k), m1_rvalid, 1'b0);
    end
    m0_req = 1'b1; m0_addr = 16'h0005; m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 16'h0010; m1_write = 1'b0;
    @(negedge clk);
    chk1("t5.after.m0Gnt", m0_gnt, 1'b1);
    chk1("t5.after.m1Gnt", m1_gnt, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0;
    waitIdle("t5.idle");

    // 6: brief m1 store request during WAIT must not reach memory
    m0_req = 1'b1; m0_addr = 16'h0010; m0_write = 1'b0;
    @(negedge clk);
    chk1("t6.m0Gnt", m0_gnt, 1'b1);
    m0_req = 1'b0;
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 16'h0005; m1_write = 1'b1; m1_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk1("t6.m0Rvalid", m0_rvalid, 1'b1);
    chk32("t6.rdata", rdata, 32'hDEADBEEF);
    chk1("t6.m1GntDone", m1_gnt, 1'b0);
    m1_req = 1'b0; m1_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("t6.m1Gnt%0d", k), m1_gnt, 1'b0);
      chk1($sformatf("t6.busy%0d", k), busy, 1'b0);
      chk1($sformatf("t6.memWrite%0d", k), mem_write, 1'b0);
    end
    doAccess(1'b0, 1'b0, 16'h0005, 32'h0, 32'h12345678, "t6post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
